mac_accum_pipe: RTL

//  Parametrised, pipelined multiply-accumulate engine; next generation of the single-shot A*B+C DSP MAC.
//  Per-beat mode: single P=A*B+C, or frame accumulation P=C+sum(A*B) over a frame closed by in_last.

---
 rtl/mac_accum_pipe.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/mac_accum_pipe.sv
// Pipelined multiply-accumulate engine: S1 operand regs, S2 product, S3 add/accumulate, output reg.
// Per-beat single A*B+C or frame accumulation C+sum(A*B), with saturation and valid/ready flow control.
module mac_accum_pipe #(
    parameter int A_W    = 8,
    parameter int B_W    = 8,
    parameter int C_W    = 8,
    parameter int ACC_W  = 24,
    parameter int CNT_W  = 8,
    parameter int SIGNED = 1,
    parameter int SAT    = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [A_W-1:0]   in_a,
    input  logic [B_W-1:0]   in_b,
    input  logic [C_W-1:0]   in_c,
    input  logic             in_acc,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_p,
    output logic             out_ovf,
    output logic [CNT_W-1:0] out_cnt
);
    localparam int PW     = A_W + B_W;
    localparam int STAGES = 3;

    typedef struct packed {
        logic [A_W-1:0] a;
        logic [B_W-1:0] b;
        logic [C_W-1:0] c;
        logic           acc;
        logic           last;
    } beat_t;

    typedef struct packed {
        logic [PW-1:0]  prod;
        logic [C_W-1:0] c;
        logic           acc;
        logic           last;
    } prod_t;

    typedef struct packed {
        logic [ACC_W-1:0] p;
        logic             ovf;
        logic [CNT_W-1:0] cnt;
    } res_t;

    beat_t             s1;
    prod_t             s2;
    res_t              s3, outr, res;
    logic [STAGES:0]   vld_pipe;
    logic [ACC_W-1:0]  acc;
    logic              frame_open, acc_ovf;
    logic [CNT_W-1:0]  acc_cnt;
    logic              stall, cont, emit, add_ovf;
    logic [PW-1:0]     prod;
    logic [ACC_W-1:0]  prod_ext, c_ext, base, sum;

    // Any output sitting unaccepted freezes the whole pipe, accumulator included.
    assign stall     = vld_pipe[STAGES] && !out_ready;
    assign in_ready  = !stall && !clr;
    assign out_valid = vld_pipe[STAGES];
    assign out_p     = outr.p;
    assign out_ovf   = outr.ovf;
    assign out_cnt   = outr.cnt;

    // Returns {overflow, result}; the result is clamped when SAT is set.
    function automatic logic [ACC_W:0] add_clamp(input logic [ACC_W-1:0] x, input logic [ACC_W-1:0] y);
        logic [ACC_W:0]   s;
        logic             o;
        logic [ACC_W-1:0] r;
        if (SIGNED != 0) begin
            s = {x[ACC_W-1], x} + {y[ACC_W-1], y};
            o = s[ACC_W] ^ s[ACC_W-1];
        end else begin
            s = {1'b0, x} + {1'b0, y};
            o = s[ACC_W];
        end
        r = s[ACC_W-1:0];
        if (SAT != 0 && o) begin
            if (SIGNED != 0)
                r = s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
            else
                r = '1;
        end
        return {o, r};
    endfunction

    always_comb begin
        if (SIGNED != 0) begin
            prod     = PW'($signed(s1.a)) * PW'($signed(s1.b));
            prod_ext = ACC_W'($signed(s2.prod));
            c_ext    = ACC_W'($signed(s2.c));
        end else begin
            prod     = PW'(s1.a) * PW'(s1.b);
            prod_ext = ACC_W'(s2.prod);
            c_ext    = ACC_W'(s2.c);
        end
    end

    // C only seeds a frame; once open the running sum replaces it.
    always_comb begin
        cont             = s2.acc && frame_open;
        base             = cont ? acc : c_ext;
        {add_ovf, sum}   = add_clamp(base, prod_ext);
        res.p            = sum;
        res.ovf          = add_ovf | (cont & acc_ovf);
        res.cnt          = !cont ? CNT_W'(1) : ((&acc_cnt) ? acc_cnt : acc_cnt + CNT_W'(1));
        emit             = !s2.acc || s2.last;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe   <= '0;
            s1         <= '0;
            s2         <= '0;
            s3         <= '0;
            outr       <= '0;
            acc        <= '0;
            frame_open <= 1'b0;
            acc_ovf    <= 1'b0;
            acc_cnt    <= '0;
        end else if (clr) begin
            vld_pipe   <= '0;
            acc        <= '0;
            frame_open <= 1'b0;
            acc_ovf    <= 1'b0;
            acc_cnt    <= '0;
            outr.ovf   <= 1'b0;
            outr.cnt   <= '0;
        end else if (!stall) begin
            vld_pipe[0] <= in_valid;
            if (in_valid)
                s1 <= '{a: in_a, b: in_b, c: in_c, acc: in_acc, last: in_last};

            vld_pipe[1] <= vld_pipe[0];
            if (vld_pipe[0])
                s2 <= '{prod: prod, c: s1.c, acc: s1.acc, last: s1.last};

            vld_pipe[2] <= vld_pipe[1] && emit;
            if (vld_pipe[1]) begin
                if (emit)
                    s3 <= res;
                if (s2.acc) begin
                    if (s2.last) begin
                        acc        <= '0;
                        frame_open <= 1'b0;
                        acc_ovf    <= 1'b0;
                        acc_cnt    <= '0;
                    end else begin
                        acc        <= sum;
                        frame_open <= 1'b1;
                        acc_ovf    <= res.ovf;
                        acc_cnt    <= res.cnt;
                    end
                end
            end

            vld_pipe[3] <= vld_pipe[2];
            if (vld_pipe[2])
                outr <= s3;
        end
    end
endmodule
